fifo_wptr_full: RTL

Write-domain pointer and flag controller for the async FIFO. It advances the write pointer on accepted writes and drives the binary RAM write address. It exports the Gray-coded write pointer that the read domain double-flops through its synchronizer. It compares against the read pointer, already synchronized into the write clock domain, to produce full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/gray2bin.sv | 17 +
 rtl/fifo_wptr_full.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types, default sizing and Gray helpers for the async FIFO pointer,
// flag and synchronizer blocks.
package fifo_pkg;

    localparam int DEFAULT_WIDTH       = 3;
    localparam int DEFAULT_DEPTH       = 1 << DEFAULT_WIDTH;
    localparam int DEFAULT_AFULL_LEVEL = 6;

    typedef logic [DEFAULT_WIDTH:0]   ptr_t;
    typedef logic [DEFAULT_WIDTH-1:0] addr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or
// above it. Shared by the write-side full logic and the read-side empty logic.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < W; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag controller for the async FIFO: advances the
// write pointer, exports it in Gray code and derives full/level/overflow flags.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int width       = DEFAULT_WIDTH,
    parameter int AFULL_LEVEL = DEFAULT_AFULL_LEVEL
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic             ovf_clr,
    input  logic [width:0]   rq2_rptr,
    output logic [width:0]   wptr,
    output logic [width-1:0] waddr,
    output logic             wclken,
    output logic             full,
    output logic             almost_full,
    output logic [width:0]   wr_level,
    output logic             overflow
);

    localparam logic [width:0] AFULL_THRESH = AFULL_LEVEL[width:0];

    logic [width:0] wbin_q, wbin_d;
    logic [width:0] wptr_q, wptr_d;
    logic [width:0] level_q, level_d;
    logic [width:0] rbin;
    logic [width:0] rptr_full_pattern;
    logic           full_q, full_d;
    logic           afull_q, afull_d;
    logic           ovf_q, ovf_d;
    logic           push;

    gray2bin #(
        .W (width + 1)
    ) u_rptr_bin (
        .gray_i (rq2_rptr),
        .bin_o  (rbin)
    );

    // Writes are gated during reset so the RAM never sees a strobe while the
    // pointer is being cleared.
    assign push = wr_en & ~full_q & resetn;

    assign rptr_full_pattern = {~rq2_rptr[width:width-1], rq2_rptr[width-2:0]};

    always_comb begin
        wbin_d  = wbin_q + {{width{1'b0}}, push};
        wptr_d  = (wbin_d >> 1) ^ wbin_d;
        full_d  = (wptr_d == rptr_full_pattern);
        level_d = wbin_d - rbin;
        afull_d = (level_d >= AFULL_THRESH);
        ovf_d   = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wptr        = wptr_q;
    assign waddr       = wbin_q[width-1:0];
    assign wclken      = push;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule
